if_fetch_unit: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID register.

---
 rtl/if_fetch_unit_pkg.sv | 15 +
 rtl/if_fetch_unit_if.sv | 10 +
 rtl/if_skid_buffer.sv | 39 +++
 rtl/if_fetch_unit.sv | 131 +++++++++++++
 tb/tb_if_fetch_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the MIPS IF stage: FSM encoding, reset defaults and constants.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_SKID = 2'd1,
      ST_KILL = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;
   localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/ack port: the fetch unit is master, the memory is slave.
interface if_fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_skid_buffer.sv
// One-entry {pc_add, instr} holding register used when a fetch returns while IF/ID is stalled.
module if_skid_buffer
   import if_fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        unload,
   input  logic        clear,
   input  logic [31:0] load_pc_add,
   input  logic [31:0] load_instr,
   output logic        valid,
   output logic [31:0] pc_add,
   output logic [31:0] instr
);

   logic        valid_reg;
   logic [31:0] pc_add_reg;
   logic [31:0] instr_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg  <= 1'b0;
         pc_add_reg <= 32'h0;
         instr_reg  <= NOP_INSTR;
      end else if (clear || unload) begin
         valid_reg <= 1'b0;
      end else if (load) begin
         valid_reg  <= 1'b1;
         pc_add_reg <= load_pc_add;
         instr_reg  <= load_instr;
      end
   end

   assign valid  = valid_reg;
   assign pc_add = pc_add_reg;
   assign instr  = instr_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, fetches over a req/ack port, and presents {PC+4, instruction} to IF/ID.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [31:0]           branch_target,
   if_fetch_unit_if.master       imem,
   output logic [31:0]           pc_add_result,
   output logic [31:0]           instruction,
   output logic                  if_id_write,
   output logic                  if_id_flush
);

   fetch_state_t state_reg;
   logic [31:0]  pc_reg;
   logic [31:0]  addr_reg;
   logic [31:0]  instr_reg;
   logic [31:0]  pc_add_reg;
   logic         req_reg;
   logic         out_valid_reg;

   logic [31:0]  pc_step_sum;
   logic [31:0]  target_aligned;
   logic         can_accept;
   logic         skid_load;
   logic         skid_unload;
   logic         skid_valid;
   logic [31:0]  skid_pc_add;
   logic [31:0]  skid_instr;

   assign pc_step_sum    = pc_reg + PC_STEP;
   assign target_aligned = branch_target & WORD_ALIGN_MASK;
   // Output slot is free, or IF/ID takes its current contents at this edge.
   assign can_accept     = !out_valid_reg || !stall;
   assign skid_load      = !branch_taken && (state_reg == ST_RUN) && req_reg && imem.ack && !can_accept;
   assign skid_unload    = !branch_taken && (state_reg == ST_SKID) && skid_valid && !stall;

   if_skid_buffer u_skid (
      .clk         (clk),
      .reset       (reset),
      .load        (skid_load),
      .unload      (skid_unload),
      .clear       (branch_taken),
      .load_pc_add (pc_step_sum),
      .load_instr  (imem.rdata),
      .valid       (skid_valid),
      .pc_add      (skid_pc_add),
      .instr       (skid_instr)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_RUN;
         pc_reg        <= RESET_PC;
         addr_reg      <= RESET_PC;
         req_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
         instr_reg     <= NOP_INSTR;
         pc_add_reg    <= 32'h0;
      end else if (branch_taken) begin
         pc_reg        <= target_aligned;
         out_valid_reg <= 1'b0;
         instr_reg     <= NOP_INSTR;
         // An unacknowledged request must finish before the new target is fetched.
         if (req_reg && !imem.ack) begin
            state_reg <= ST_KILL;
         end else begin
            state_reg <= ST_RUN;
            req_reg   <= 1'b1;
            addr_reg  <= target_aligned;
         end
      end else begin
         case (state_reg)
            ST_RUN: begin
               if (req_reg && imem.ack) begin
                  pc_reg <= pc_step_sum;
                  if (can_accept) begin
                     instr_reg     <= imem.rdata;
                     pc_add_reg    <= pc_step_sum;
                     out_valid_reg <= 1'b1;
                     addr_reg      <= pc_step_sum;
                  end else begin
                     req_reg   <= 1'b0;
                     state_reg <= ST_SKID;
                  end
               end else begin
                  if (!stall) begin
                     out_valid_reg <= 1'b0;
                  end
                  if (!req_reg && can_accept) begin
                     req_reg  <= 1'b1;
                     addr_reg <= pc_reg;
                  end
               end
            end
            ST_SKID: begin
               if (skid_unload) begin
                  instr_reg     <= skid_instr;
                  pc_add_reg    <= skid_pc_add;
                  out_valid_reg <= 1'b1;
                  req_reg       <= 1'b1;
                  addr_reg      <= pc_reg;
                  state_reg     <= ST_RUN;
               end
            end
            ST_KILL: begin
               if (imem.ack) begin
                  req_reg   <= 1'b1;
                  addr_reg  <= pc_reg;
                  state_reg <= ST_RUN;
               end
            end
            default: state_reg <= ST_RUN;
         endcase
      end
   end

   assign imem.req      = req_reg;
   assign imem.addr     = addr_reg;
   assign instruction   = instr_reg;
   assign pc_add_result = pc_add_reg;
   assign if_id_write   = !stall;
   assign if_id_flush   = !out_valid_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table, reset corner cases, and randomized run against a stream model.
module tb_if_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] pc_add_result;
   logic [31:0] instruction;
   logic        if_id_write;
   logic        if_id_flush;

   if_fetch_unit_if imem_bus ();

   if_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem          (imem_bus),
      .pc_add_result (pc_add_result),
      .instruction   (instruction),
      .if_id_write   (if_id_write),
      .if_id_flush   (if_id_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_errors;

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      logic        ack;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_flush;
      logic        chk_data;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc_add;
   } vec_t;

   localparam int NVEC = 26;
   vec_t vecs [NVEC];

   // Contents of the instruction memory: distinct, never equal to a nop.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
   endfunction

   function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t, input logic a,
                               input logic er, input logic [31:0] ea, input logic ef,
                               input logic cd, input logic [31:0] ei, input logic [31:0] ep);
      vec_t v;
      v.stall = s; v.br = b; v.tgt = t; v.ack = a;
      v.exp_req = er; v.exp_addr = ea; v.exp_flush = ef;
      v.chk_data = cd; v.exp_instr = ei; v.exp_pc_add = ep;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive_row(input int i);
      stall          = vecs[i].stall;
      branch_taken   = vecs[i].br;
      branch_target  = vecs[i].tgt;
      imem_bus.ack   = vecs[i].ack;
      imem_bus.rdata = mem_word(imem_bus.addr);
   endtask

   task automatic apply_row(input int i);
      drive_row(i);
      #1;
      check($sformatf("row%0d req", i), {31'b0, imem_bus.req}, {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req) check($sformatf("row%0d addr", i), imem_bus.addr, vecs[i].exp_addr);
      check($sformatf("row%0d flush", i), {31'b0, if_id_flush}, {31'b0, vecs[i].exp_flush});
      check($sformatf("row%0d write", i), {31'b0, if_id_write}, {31'b0, !vecs[i].stall});
      if (vecs[i].chk_data) begin
         check($sformatf("row%0d instr", i), instruction, vecs[i].exp_instr);
         check($sformatf("row%0d pc_add", i), pc_add_result, vecs[i].exp_pc_add);
      end
      $display("row %0d: req=%0b addr=%08h flush=%0b instr=%08h pc_add=%08h",
               i, imem_bus.req, imem_bus.addr, if_id_flush, instruction, pc_add_result);
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      imem_bus.ack = 1'b0; imem_bus.rdata = 32'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " req"}, {31'b0, imem_bus.req}, 32'h0);
      check({tag, " addr"}, imem_bus.addr, 32'h0);
      check({tag, " instr"}, instruction, 32'h0);
      check({tag, " pc_add"}, pc_add_result, 32'h0);
      check({tag, " flush"}, {31'b0, if_id_flush}, 32'h1);
      $display("%s: req=%0b addr=%08h instr=%08h flush=%0b", tag, imem_bus.req, imem_bus.addr, instruction, if_id_flush);
   endtask

   // Reset asserted mid-cycle; outputs must clear without a clock edge, then fetch restarts at RESET_PC.
   task automatic reset_midcycle(input string tag);
      #2 reset = 1'b1;
      #1 check_reset_values(tag);
      @(posedge clk); #1;
      reset = 1'b0;
      idle_inputs();
      @(posedge clk); #1;
      check({tag, " restart req"}, {31'b0, imem_bus.req}, 32'h1);
      check({tag, " restart addr"}, imem_bus.addr, 32'h0);
      $display("%s restart: req=%0b addr=%08h", tag, imem_bus.req, imem_bus.addr);
   endtask

   initial begin
      logic [31:0] exp_pc;
      logic        prev_wait;
      logic [31:0] prev_addr;
      logic        mem_busy;
      int          wait_left;
      int          consumed;

      n_checks = 0;
      n_errors = 0;

      // Same-cycle memory, 3-cycle stall into skid, kill on redirect, wrap at top of memory, 2-wait memory.
      vecs[ 0] = mk(0,0,32'h0,0, 0,32'h0,1, 0,32'h0,32'h0);
      vecs[ 1] = mk(0,0,32'h0,1, 1,32'h0,1, 0,32'h0,32'h0);
      vecs[ 2] = mk(0,0,32'h0,1, 1,32'h4,0, 1,mem_word(32'h0),32'h4);
      vecs[ 3] = mk(0,0,32'h0,1, 1,32'h8,0, 1,mem_word(32'h4),32'h8);
      vecs[ 4] = mk(0,0,32'h0,1, 1,32'hC,0, 1,mem_word(32'h8),32'hC);
      vecs[ 5] = mk(1,0,32'h0,1, 1,32'h10,0, 1,mem_word(32'hC),32'h10);
      vecs[ 6] = mk(1,0,32'h0,0, 0,32'h0,0, 1,mem_word(32'hC),32'h10);
      vecs[ 7] = mk(1,0,32'h0,0, 0,32'h0,0, 1,mem_word(32'hC),32'h10);
      vecs[ 8] = mk(0,0,32'h0,0, 0,32'h0,0, 1,mem_word(32'hC),32'h10);
      vecs[ 9] = mk(0,0,32'h0,1, 1,32'h14,0, 1,mem_word(32'h10),32'h14);
      vecs[10] = mk(0,0,32'h0,1, 1,32'h18,0, 1,mem_word(32'h14),32'h18);
      vecs[11] = mk(0,0,32'h0,1, 1,32'h1C,0, 1,mem_word(32'h18),32'h1C);
      vecs[12] = mk(0,0,32'h0,0, 1,32'h20,0, 1,mem_word(32'h1C),32'h20);
      vecs[13] = mk(0,1,32'h43,0, 1,32'h20,1, 0,32'h0,32'h0);
      vecs[14] = mk(0,0,32'h0,1, 1,32'h20,1, 0,32'h0,32'h0);
      vecs[15] = mk(0,0,32'h0,1, 1,32'h40,1, 0,32'h0,32'h0);
      vecs[16] = mk(0,1,32'hFFFF_FFFC,1, 1,32'h44,0, 1,mem_word(32'h40),32'h44);
      vecs[17] = mk(0,0,32'h0,1, 1,32'hFFFF_FFFC,1, 0,32'h0,32'h0);
      vecs[18] = mk(0,0,32'h0,1, 1,32'h0,0, 1,mem_word(32'hFFFF_FFFC),32'h0);
      vecs[19] = mk(0,0,32'h0,0, 1,32'h4,0, 1,mem_word(32'h0),32'h4);
      vecs[20] = mk(0,0,32'h0,0, 1,32'h4,1, 0,32'h0,32'h0);
      vecs[21] = mk(0,0,32'h0,1, 1,32'h4,1, 0,32'h0,32'h0);
      vecs[22] = mk(0,0,32'h0,0, 1,32'h8,0, 1,mem_word(32'h4),32'h8);
      vecs[23] = mk(0,0,32'h0,0, 1,32'h8,1, 0,32'h0,32'h0);
      vecs[24] = mk(0,0,32'h0,1, 1,32'h8,1, 0,32'h0,32'h0);
      vecs[25] = mk(0,0,32'h0,0, 1,32'hC,0, 1,mem_word(32'h8),32'hC);

      reset = 1'b1;
      idle_inputs();
      @(posedge clk); #1;
      check_reset_values("reset held");
      reset = 1'b0;
      for (int i = 0; i < NVEC; i++) apply_row(i);

      // Reset while waiting on the 0x20 request with a valid word on the outputs.
      do_reset();
      for (int i = 0; i < 12; i++) apply_row(i);
      drive_row(12);
      reset_midcycle("reset mid-wait");

      // Reset while a word sits in the skid buffer.
      do_reset();
      for (int i = 0; i < 8; i++) apply_row(i);
      stall = 1'b1;
      imem_bus.ack = 1'b0;
      reset_midcycle("reset mid-skid");

      // Random stalls, redirects and 0..2 wait-state memory against the expected instruction stream.
      do_reset();
      exp_pc    = 32'h0;
      prev_wait = 1'b0;
      prev_addr = 32'h0;
      mem_busy  = 1'b0;
      wait_left = 0;
      consumed  = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (mem_busy) begin
            if (imem_bus.ack) mem_busy = 1'b0;
            else if (wait_left > 0) wait_left--;
         end
         if (imem_bus.req && !mem_busy) begin
            mem_busy  = 1'b1;
            wait_left = $urandom_range(0, 2);
         end
         imem_bus.ack   = mem_busy && (wait_left == 0);
         imem_bus.rdata = mem_word(imem_bus.addr);
         stall          = ($urandom_range(0, 3) == 0);
         branch_taken   = ($urandom_range(0, 24) == 0);
         branch_target  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : ($urandom & 32'h0000_FFFF);
         #1;
         if (prev_wait) begin
            check("rand req held", {31'b0, imem_bus.req}, 32'h1);
            check("rand addr held", imem_bus.addr, prev_addr);
         end
         if (branch_taken) begin
            exp_pc = branch_target & 32'hFFFF_FFFC;
         end else if (!stall && !if_id_flush) begin
            check("rand instr", instruction, mem_word(exp_pc));
            check("rand pc_add", pc_add_result, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         prev_wait = imem_bus.req && !imem_bus.ack;
         prev_addr = imem_bus.addr;
         @(posedge clk); #1;
      end
      n_checks++;
      if (consumed < 200) begin
         n_errors++;
         $display("FAIL rand throughput: consumed %0d instructions, required at least 200", consumed);
      end
      $display("random phase: %0d instructions consumed", consumed);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
